// File: rtl/washer_pkg.sv
// washer_pkg: shared washer types and constants used by the fill arbiter and the washing_machine controllers
package washer_pkg;
  typedef enum logic [1:0] {IDLE, FILL, GAP} fill_state_e;
  localparam logic [1:0] CLK_1MHZ = 2'b00;
  localparam logic [1:0] CLK_2MHZ = 2'b01;
  localparam logic [1:0] CLK_4MHZ = 2'b10;
  localparam logic [1:0] CLK_8MHZ = 2'b11;
  localparam int MAX_FILL_MINUTES = 15;
endpackage

// File: rtl/laundromat_fill_arbiter_if.sv
// laundromat_fill_arbiter_if: fill-valve request/grant bundle between the washer controllers and the arbiter
// clk_freq, timer_pause, fill_req: controller side to arbiter
// fill_grant, fill_done, owner, busy: arbiter to controllers and valve mux
interface laundromat_fill_arbiter_if #(parameter int N = 4);
  logic [1:0] clk_freq;
  logic timer_pause;
  logic [N-1:0] fill_req;
  logic [N-1:0] fill_grant;
  logic [N-1:0] fill_done;
  logic [2:0] owner;
  logic busy;
  modport master (output clk_freq, timer_pause, fill_req, input fill_grant, fill_done, owner, busy);
  modport slave (input clk_freq, timer_pause, fill_req, output fill_grant, fill_done, owner, busy);
endinterface

// File: rtl/fill_minute_timer.sv
// fill_minute_timer: per-fill cycle and minute counters with pause hold, flags the final minute wrap
// start_i: clears counters and latches clk_freq_i; run_i: counts when high
// fill_expired_o: high in the cycle whose clock edge completes the last minute
module fill_minute_timer
  import washer_pkg::*;
#(
  parameter int TICK_BASE = 60_000_000,
  parameter int FILL_MINUTES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       run_i,
  input  logic [1:0] clk_freq_i,
  output logic       fill_expired_o
);
  localparam int CW = $clog2(TICK_BASE * 8);
  localparam int MW = $clog2(MAX_FILL_MINUTES + 1);
  logic [1:0] freq_q;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [MW-1:0] min_q, min_d;
  logic [CW:0] lim;
  logic wrap;
  // lim carries one extra bit so a power-of-two TICK_BASE shifted by 3 still fits
  always_comb begin
    lim = (CW+1)'(TICK_BASE) << freq_q;
    wrap = run_i && ({1'b0, cyc_q} == lim - 1'b1);
    fill_expired_o = wrap && (min_q == MW'(FILL_MINUTES - 1));
    cyc_d = start_i ? '0 : !run_i ? cyc_q : wrap ? '0 : cyc_q + 1'b1;
    min_d = start_i ? '0 : wrap ? min_q + 1'b1 : min_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_q <= CLK_1MHZ;
      cyc_q <= '0;
      min_q <= '0;
    end else begin
      freq_q <= start_i ? clk_freq_i : freq_q;
      cyc_q <= cyc_d;
      min_q <= min_d;
    end
  end
endmodule

// File: rtl/laundromat_fill_arbiter.sv
// laundromat_fill_arbiter: round-robin owner of the shared hot-water fill valve, one timed fill at a time
// clk, rst_n: system clock and asynchronous active-low reset
// bus (slave): clk_freq/timer_pause/fill_req in, fill_grant/fill_done/owner/busy out, all outputs registered
module laundromat_fill_arbiter
  import washer_pkg::*;
#(
  parameter int N_MACHINES = 4,
  parameter int FILL_MINUTES = 2,
  parameter int TICK_BASE = 60_000_000
) (
  input logic clk,
  input logic rst_n,
  laundromat_fill_arbiter_if.slave bus
);
  fill_state_e state_q;
  logic [N_MACHINES-1:0] grant_q, done_q;
  logic [2:0] owner_q, last_q, win;
  logic busy_q, start, expired, owner_req;
  // scan from farthest to nearest so the requester right after last_q wins
  always_comb begin
    win = last_q;
    for (int k = N_MACHINES; k >= 1; k--)
      if (|(bus.fill_req & (N_MACHINES'(1) << ((int'(last_q) + k) % N_MACHINES))))
        win = 3'((int'(last_q) + k) % N_MACHINES);
    start = (state_q == IDLE) && |bus.fill_req;
    owner_req = |(bus.fill_req & grant_q);
  end
  fill_minute_timer #(.TICK_BASE(TICK_BASE), .FILL_MINUTES(FILL_MINUTES)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start),
    .run_i((state_q == FILL) && !bus.timer_pause),
    .clk_freq_i(bus.clk_freq),
    .fill_expired_o(expired)
  );
  // completion wins over a same-edge request drop, so done follows expired alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q <= '0;
      owner_q <= '0;
      busy_q <= 1'b0;
      last_q <= 3'(N_MACHINES - 1);
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= FILL;
          grant_q <= N_MACHINES'(1) << win;
          owner_q <= win;
          busy_q <= 1'b1;
        end
        FILL: if (expired || !owner_req) begin
          state_q <= GAP;
          grant_q <= '0;
          owner_q <= '0;
          busy_q <= 1'b0;
          last_q <= owner_q;
          done_q <= expired ? grant_q : '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.fill_grant = grant_q;
  assign bus.fill_done = done_q;
  assign bus.owner = owner_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_laundromat_fill_arbiter.sv
// tb_laundromat_fill_arbiter: directed scenarios with a fill scoreboard for laundromat_fill_arbiter
module tb_laundromat_fill_arbiter;
  import washer_pkg::*;
  localparam int N = 4;
  localparam int TB = 10;
  localparam int FM = 2;
  typedef struct {
    logic [N-1:0] grant;
    logic [2:0] owner;
    int len;
    bit done;
    int gap;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_pass = 0;
  exp_t sb[$];
  laundromat_fill_arbiter_if #(.N(N)) bus ();
  laundromat_fill_arbiter #(.N_MACHINES(N), .FILL_MINUTES(FM), .TICK_BASE(TB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic int exp_len(int f, int p);
    return FM * (TB << f) + p;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input logic [N-1:0] g, input logic [2:0] o, input int len, input bit d, input int gap);
    exp_t e;
    e.grant = g;
    e.owner = o;
    e.len = len;
    e.done = d;
    e.gap = gap;
    sb.push_back(e);
  endtask
  task automatic wait_done(input int m, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.fill_done[m]) break;
    end
    check($sformatf("done_seen_%0d", m), 32'(bus.fill_done[m]), 1);
  endtask
  task automatic do_reset();
    bus.fill_req = '0;
    bus.timer_pause = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_grant", 32'(bus.fill_grant), 0);
    check("rst_done", 32'(bus.fill_done), 0);
    check("rst_owner", 32'(bus.owner), 0);
    check("rst_busy", 32'(bus.busy), 0);
    step(2);
    rst_n = 1'b1;
  endtask
  // tracks each grant episode and scores it against the head of the queue
  task automatic monitor();
    logic [N-1:0] g = '0;
    int len = 0;
    int low = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (g != 0 && sb.size() > 0) void'(sb.pop_front());
        g = '0;
        len = 0;
        low = 0;
      end else if (bus.fill_grant != 0) begin
        if (g == 0) begin
          if (sb.size() == 0) check("unexpected_grant", 32'(bus.fill_grant), 0);
          else begin
            e = sb[0];
            if (e.gap >= 0) check("gap", low, e.gap);
            check("owner", 32'(bus.owner), 32'(e.owner));
            check("busy_on", 32'(bus.busy), 1);
          end
          g = bus.fill_grant;
          len = 0;
        end else check("grant_hold", 32'(bus.fill_grant), 32'(g));
        len++;
      end else begin
        if (g != 0 && sb.size() > 0) begin
          e = sb.pop_front();
          check("grant", 32'(g), 32'(e.grant));
          check("len", len, e.len);
          check("done", 32'(bus.fill_done), e.done ? 32'(e.grant) : 0);
          check("busy_off", 32'(bus.busy), 0);
          low = 0;
        end else check("spurious_done", 32'(bus.fill_done), 0);
        g = '0;
        low++;
      end
    end
  endtask
  initial begin
    rst_n = 1'b1;
    bus.clk_freq = CLK_1MHZ;
    bus.timer_pause = 1'b0;
    bus.fill_req = '0;
    @(negedge clk);
    do_reset();
    fork
      monitor();
    join_none
    push(4'b0001, 0, exp_len(0, 0), 1, -1);
    bus.fill_req = 4'b0001;
    wait_done(0, 100);
    bus.fill_req = '0;
    step(3);
    check("t1_idle", 32'(bus.busy), 0);
    do_reset();
    push(4'b0001, 0, exp_len(0, 0), 1, -1);
    push(4'b0010, 1, exp_len(0, 0), 1, 2);
    push(4'b0100, 2, exp_len(0, 0), 1, 2);
    push(4'b1000, 3, exp_len(0, 0), 1, 2);
    push(4'b0001, 0, exp_len(0, 0), 1, 2);
    bus.fill_req = 4'b1111;
    wait_done(3, 200);
    bus.fill_req = 4'b0001;
    wait_done(0, 100);
    bus.fill_req = '0;
    do_reset();
    bus.clk_freq = CLK_8MHZ;
    push(4'b0001, 0, exp_len(3, 0), 1, -1);
    bus.fill_req = 4'b0001;
    step(30);
    bus.clk_freq = CLK_1MHZ;
    wait_done(0, 400);
    bus.fill_req = '0;
    do_reset();
    push(4'b0001, 0, exp_len(0, 5), 1, -1);
    bus.fill_req = 4'b0001;
    step(8);
    bus.timer_pause = 1'b1;
    step(3);
    check("pause_owner", 32'(bus.owner), 0);
    check("pause_grant", 32'(bus.fill_grant), 1);
    step(2);
    bus.timer_pause = 1'b0;
    wait_done(0, 100);
    bus.fill_req = '0;
    do_reset();
    push(4'b0001, 0, 7, 0, -1);
    push(4'b0010, 1, exp_len(0, 0), 1, 2);
    bus.fill_req = 4'b0011;
    step(7);
    bus.fill_req = 4'b0010;
    wait_done(1, 100);
    bus.fill_req = '0;
    do_reset();
    push(4'b0001, 0, -1, 0, -1);
    bus.fill_req = 4'b0001;
    step(10);
    #2 rst_n = 1'b0;
    #1;
    check("async_grant", 32'(bus.fill_grant), 0);
    check("async_busy", 32'(bus.busy), 0);
    check("async_done", 32'(bus.fill_done), 0);
    step(2);
    rst_n = 1'b1;
    push(4'b0010, 1, exp_len(0, 0), 1, -1);
    push(4'b1000, 3, exp_len(0, 0), 1, 2);
    bus.fill_req = 4'b1010;
    wait_done(1, 100);
    bus.fill_req = 4'b1000;
    wait_done(3, 100);
    bus.fill_req = '0;
    step(5);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
